fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Instruction-fetch stage directly downstream of the PC register. Takes the word-indexed PC
//  (PC advances by 1 per instruction) and reads a synchronous instruction memory. Buffers fetched
//  {pc, instr, fault} in a small FIFO toward decode under a valid/ready handshake.
//  Backpressures the PC stage through fetch_stall and discards wrong-path work on flush.
// PARAMETERS
//  ADDR_W  8  instruction memory depth = 2**ADDR_W words of 32 bits
//  DEPTH   4  fetch queue entries; power of two, >= 2
// PORTS
//  clk          in   1       clock, all state updates on rising edge
//  rst          in   1       synchronous, active-high reset
//  pc_in        in   32      word index of instruction to fetch
//  fetch_req    in   1       pc_in valid this cycle
//  flush        in   1       taken branch/redirect: kill queue and in-flight read
//  fetch_stall  out  1       upstream must hold pc_in; request this cycle ignored
//  imem_we      in   1       memory load port write enable (bench/boot loader)
//  imem_waddr   in   ADDR_W  memory load address (word)
//  imem_wdata   in   32      memory load data
//  id_valid     out  1       queue head valid toward decode
//  id_ready     in   1       decode accepts head this cycle
//  id_instr     out  32      head instruction
//  id_pc        out  32      head PC
//  id_fault     out  1       head PC was outside memory range
// BEHAVIOUR
//  Reset: queue empty, in-flight flag s1_valid=0; id_valid=0, id_instr=0, id_pc=0, id_fault=0,
//   fetch_stall=0. Memory contents are not reset.
//  Stall: fetch_stall = (count + s1_valid >= DEPTH). Driven from registers only, no comb path
//   from inputs. This reserves a slot for the in-flight read, so a push never meets a full queue.
//  Accept: cycle N with fetch_req & !fetch_stall & !flush issues a read at pc_in[ADDR_W-1:0],
//   latches pc_in, and sets s1_valid.
//  Read: memory data is valid in N+1 and is pushed at the end of N+1.
//   Entry is visible on id_* in N+2, so minimum latency is 2 cycles. No bypass when empty.
//  Fault: if pc_in[31:ADDR_W] != 0, the entry gets instr=32'h00000013 (NOP) and fault=1.
//   The memory read result is ignored for that entry.
//  Pop: on id_valid & id_ready, the head advances. Push and pop in the same cycle leave count
//   unchanged. Pointers wrap modulo DEPTH; count spans 0..DEPTH.
//  id_* outputs: show the head entry when id_valid=1, else 0.
//  Flush (highest priority): next cycle count=0, pointers=0, s1_valid=0.
//   The data in flight is not pushed, and a request presented in the flush cycle is not accepted.
//   A pop in the flush cycle is a don't-care for decode.
//  Memory write: synchronous. A write and a read to the same address in the same cycle return
//   the old data (read-first).
//  Reset mid-operation behaves like flush and also clears the id_* registers.
//  Arithmetic: queue is unsigned; PC is stored verbatim (32 bits), and only the low ADDR_W bits
//   index memory.
// TESTING
//  1 rst=1 two cycles, then idle -> id_valid=0, id_instr=0, fetch_stall=0.
//  2 load imem[1..4]=32'hA1..A4, id_ready=1, req pc 1,2,3,4 at cycles 0..3 -> id_valid in
//    cycles 2..5, with id_pc=1..4 and id_instr=A1..A4 in order.
//  3 id_ready=0, fetch_req held high (DEPTH=4) -> exactly 4 requests accepted; fetch_stall=1
//    from cycle 4. Then raise id_ready -> 4 pops in order, and stall drops once
//    count+s1_valid<4.
//  4 queue holding 3 entries plus one in flight, flush=1 with fetch_req=1 -> next cycle
//    id_valid=0. The in-flight entry and the request never appear; a new request afterwards
//    appears 2 cycles later.
//  5 ADDR_W=8, pc_in=32'h100 -> id_instr=32'h00000013, id_fault=1, id_pc=32'h100.
//  6 imem_we to addr 5 (old 32'h11, new 32'h22) in the same cycle as a req to pc 5 ->
//    id_instr=32'h11; a later req to pc 5 -> 32'h22.

Source files
------------

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch stage: synchronous imem read feeding a small decode queue
module fetch_queue #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pc_in,
    input  logic              fetch_req,
    input  logic              flush,
    output logic              fetch_stall,
    input  logic              imem_we,
    input  logic [ADDR_W-1:0] imem_waddr,
    input  logic [31:0]       imem_wdata,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [31:0]       id_instr,
    output logic [31:0]       id_pc,
    output logic              id_fault
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic [31:0]      mem [0:(1<<ADDR_W)-1];
    logic [31:0]      rdata;

    logic             s1_valid;
    logic [31:0]      s1_pc;
    logic             s1_fault;

    logic [31:0]      q_pc    [0:DEPTH-1];
    logic [31:0]      q_instr [0:DEPTH-1];
    logic             q_fault [0:DEPTH-1];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   occupancy;

    logic             accept;
    logic             pc_fault;
    logic             push;
    logic             pop;
    logic [31:0]      push_instr;

    // Occupancy counts the in-flight read so a slot is always reserved for it;
    // built only from registers so the stall has no path from this cycle's inputs.
    always_comb begin
        occupancy   = {1'b0, count} + {{CNT_W{1'b0}}, s1_valid};
        fetch_stall = (occupancy >= (CNT_W+1)'(DEPTH));
        accept      = fetch_req & ~fetch_stall & ~flush;
        pc_fault    = |pc_in[31:ADDR_W];
        push        = s1_valid & ~flush;
        pop         = id_valid & id_ready & ~flush;
        push_instr  = s1_fault ? NOP_INSTR : rdata;
    end

    // Instruction memory: load port write and read-first fetch read
    always_ff @(posedge clk) begin
        if (imem_we) begin
            mem[imem_waddr] <= imem_wdata;
        end
        if (accept) begin
            rdata <= mem[pc_in[ADDR_W-1:0]];
        end
    end

    // In-flight stage: remembers PC and range fault of the read issued last cycle
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            s1_valid <= 1'b0;
            s1_pc    <= '0;
            s1_fault <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_pc    <= pc_in;
                s1_fault <= pc_fault;
            end
        end
    end

    // Queue storage write: the completed read lands at the tail
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= s1_pc;
            q_instr[wr_ptr] <= push_instr;
            q_fault[wr_ptr] <= s1_fault;
        end
    end

    // Queue pointers and count; flush and reset empty the queue outright
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Head presentation toward decode, forced to zero whenever the queue is empty
    always_comb begin
        id_valid = (count != '0);
        id_instr = '0;
        id_pc    = '0;
        id_fault = 1'b0;
        if (id_valid) begin
            id_instr = q_instr[rd_ptr];
            id_pc    = q_pc[rd_ptr];
            id_fault = q_fault[rd_ptr];
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue
module tb_fetch_queue;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       pc_in;
    logic              fetch_req;
    logic              flush;
    logic              fetch_stall;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              id_valid;
    logic              id_ready;
    logic [31:0]       id_instr;
    logic [31:0]       id_pc;
    logic              id_fault;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } ent_t;

    ent_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    logic mon_en = 1'b0;

    fetch_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .fetch_req(fetch_req), .flush(flush),
        .fetch_stall(fetch_stall), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_pc(id_pc), .id_fault(id_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_entry(input logic [31:0] pc, input logic [31:0] instr, input logic fault);
        ent_t e;
        e.pc    = pc;
        e.instr = instr;
        e.fault = fault;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 30) begin
            step();
            k++;
        end
        chk({name, "_drain_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Monitor: every accepted head is popped from the scoreboard and compared
    always @(negedge clk) begin
        if (mon_en) begin
            if (id_valid && id_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_pop: got pc %h instr %h expected no entry", id_pc, id_instr);
                end else begin
                    ent_t e;
                    e = exp_q.pop_front();
                    chk("pop_pc", id_pc, e.pc);
                    chk("pop_instr", id_instr, e.instr);
                    chk("pop_fault", {31'b0, id_fault}, {31'b0, e.fault});
                end
            end
            if (!id_valid) begin
                chk("idle_zero", {id_instr | id_pc, 31'b0, id_fault}, 64'b0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; pc_in = '0; fetch_req = 1'b0; flush = 1'b0;
        imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0; id_ready = 1'b0;

        // Test 1: reset
        step(); step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_id_valid", {31'b0, id_valid}, 0);
        chk("rst_id_instr", id_instr, 0);
        chk("rst_id_pc", id_pc, 0);
        chk("rst_id_fault", {31'b0, id_fault}, 0);
        chk("rst_stall", {31'b0, fetch_stall}, 0);

        // Memory preload
        for (int i = 1; i <= 4; i++) begin
            step();
            imem_we = 1'b1; imem_waddr = ADDR_W'(i); imem_wdata = 32'hA0 + 32'(i);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            imem_we = 1'b1; imem_waddr = ADDR_W'(10 + i); imem_wdata = 32'hB0 + 32'(i);
        end
        step();
        imem_we = 1'b1; imem_waddr = 8'd5; imem_wdata = 32'h11;
        step();
        imem_we = 1'b0;
        mon_en = 1'b1;

        // Test 2: back-to-back fetch, 2-cycle latency
        id_ready = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            step();
            if (k < 4) begin
                fetch_req = 1'b1; pc_in = 32'(k + 1);
                expect_entry(32'(k + 1), 32'hA1 + 32'(k), 1'b0);
            end else begin
                fetch_req = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("t2_valid_c%0d", k), {31'b0, id_valid}, (k >= 2 && k <= 5) ? 1 : 0);
        end
        drain("t2");

        // Test 3: fill under backpressure, then release
        id_ready = 1'b0;
        for (int k = 0; k <= 9; k++) begin
            step();
            if (k < 4) begin
                fetch_req = 1'b1; pc_in = 32'(10 + k);
                expect_entry(32'(10 + k), 32'hB0 + 32'(k), 1'b0);
            end else if (k < 8) begin
                fetch_req = 1'b1; pc_in = 32'd14;
            end else begin
                fetch_req = 1'b0; id_ready = 1'b1;
            end
            @(negedge clk);
            chk($sformatf("t3_stall_c%0d", k), {31'b0, fetch_stall}, (k >= 4 && k <= 8) ? 1 : 0);
        end
        drain("t3");

        // Test 4: flush with three queued, one in flight and a request present
        id_ready = 1'b0;
        for (int k = 0; k <= 7; k++) begin
            step();
            fetch_req = 1'b0; flush = 1'b0;
            if (k < 4) begin
                fetch_req = 1'b1; pc_in = 32'(k + 1);
                expect_entry(32'(k + 1), 32'hA1 + 32'(k), 1'b0);
            end else if (k == 4) begin
                fetch_req = 1'b1; pc_in = 32'd3; flush = 1'b1;
                exp_q.delete();
            end else if (k == 5) begin
                id_ready = 1'b1;
                fetch_req = 1'b1; pc_in = 32'd2;
                expect_entry(32'd2, 32'hA2, 1'b0);
            end
            @(negedge clk);
            if (k == 4) chk("t4_count_before_flush", {31'b0, id_valid}, 1);
            if (k >= 5) chk($sformatf("t4_valid_c%0d", k), {31'b0, id_valid}, (k == 7) ? 1 : 0);
        end
        drain("t4");

        // Test 5: out-of-range PC becomes a faulting NOP
        step();
        fetch_req = 1'b1; pc_in = 32'h100;
        expect_entry(32'h100, 32'h0000_0013, 1'b1);
        step();
        fetch_req = 1'b0;
        drain("t5");

        // Test 6: write and read same address in one cycle returns old data
        step();
        imem_we = 1'b1; imem_waddr = 8'd5; imem_wdata = 32'h22;
        fetch_req = 1'b1; pc_in = 32'd5;
        expect_entry(32'd5, 32'h11, 1'b0);
        step();
        imem_we = 1'b0; fetch_req = 1'b0;
        drain("t6a");
        step();
        fetch_req = 1'b1; pc_in = 32'd5;
        expect_entry(32'd5, 32'h22, 1'b0);
        step();
        fetch_req = 1'b0;
        drain("t6b");

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
